// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM among NUM_CORES cores; define DRAM_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
// Latency: write ack at t+2, read ack/rdata at t+1+RD_LAT; one transaction at a time, req held until the ack pulse.
module dram_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);
    localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d, win;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [NUM_CORES-1:0] gnt_q, gnt_d, ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 mem_we_q, mem_we_d, busy_q, busy_d;
`ifndef DRAM_ARB_FIXED_PRIO_EN
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    // Reverse scan so the candidate closest to the search start wins.
    always_comb begin
        win = '0;
`ifdef DRAM_ARB_FIXED_PRIO_EN
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) win = SEL_W'(i);
        end
`else
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr_q) + k) % NUM_CORES])
                win = SEL_W'((int'(rr_ptr_q) + k) % NUM_CORES);
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d       = win;
                    we_d        = we[win];
                    mem_addr_d  = addr[int'(win)*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata[int'(win)*DATA_W +: DATA_W];
                    mem_we_d    = we[win];
                    gnt_d       = '0;
                    gnt_d[win]  = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q || RD_LAT == 1) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // DONE is only ever entered from ISSUE or WAIT, so this fires once per transaction.
        if (state_d == DONE) begin
            ack_d[sel_q] = 1'b1;
            if (!we_q) rdata_d = mem_rdata;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            gnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
        end
    end

`ifndef DRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == DONE) rr_ptr_d = SEL_W'((int'(sel_q) + 1) % NUM_CORES);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr_q <= '0;
        else      rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic             clk, rst;
    logic [NC-1:0]    req, we, gnt, ack;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;
    logic [DW-1:0]    rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]    mem_addr;
    logic             mem_we, busy;

    dram_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] + 8'h2A;
    endfunction
    assign mem_rdata = mem_f(mem_addr);

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ack;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    typedef struct {
        int          core;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_rdata;
        int          exp_lat;
    } vec_t;

    exp_t exp_q[$];
    int   ack_times[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_count = 0;
    int   wr_cnt = 0;
    logic [15:0] wr_addr_seen;
    logic [7:0]  wr_data_seen;
    logic [7:0]  exp_last_rdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected transaction.
    initial begin
        exp_t e;
        exp_last_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wr_cnt = 0;
                exp_last_rdata = 8'h00;
            end else begin
                if (mem_we) begin
                    wr_cnt++;
                    wr_addr_seen = mem_addr;
                    wr_data_seen = mem_wdata;
                end
                if (ack != '0) begin
                    ack_count++;
                    ack_times.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 64'(ack), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_ack", 64'(ack), 64'(e.ack));
                        if (e.we) begin
                            chk("sb_wr_cycles", 64'(wr_cnt), 64'd1);
                            chk("sb_wr_addr", 64'(wr_addr_seen), 64'(e.addr));
                            chk("sb_wr_data", 64'(wr_data_seen), 64'(e.wdata));
                            chk("sb_rdata_hold", 64'(rdata), 64'(exp_last_rdata));
                        end else begin
                            chk("sb_rdata", 64'(rdata), 64'(e.rdata));
                            chk("sb_rd_no_we", 64'(wr_cnt), 64'd0);
                            exp_last_rdata = e.rdata;
                        end
                    end
                    wr_cnt = 0;
                end
            end
        end
    end

    task automatic drive(input int c, input logic w, input logic [15:0] a, input logic [7:0] d);
        we[c] = w;
        addr[c*AW +: AW] = a;
        wdata[c*DW +: DW] = d;
        req[c] = 1'b1;
    endtask

    task automatic push(input int c, input logic w, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.ack = 4'b0001 << c;
        e.we = w;
        e.addr = a;
        e.wdata = d;
        e.rdata = mem_f(a);
        exp_q.push_back(e);
    endtask

    task automatic wait_acks(input int n, input bit drop, input int budget);
        int seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                seen++;
                if (drop) req = req & ~ack;
            end
        end
        chk("ack_timeout", 64'(seen), 64'(n));
        #1;
    endtask

    initial begin
        vec_t vecs[6];
        int   lat, base, n;
        vecs[0] = '{core: 2, we: 1'b1, addr: 16'h0040, wdata: 8'hA5, exp_ack: 4'b0100, exp_rdata: 8'h00, exp_lat: 2};
        vecs[1] = '{core: 0, we: 1'b0, addr: 16'h0012, wdata: 8'h00, exp_ack: 4'b0001, exp_rdata: 8'h3C, exp_lat: 3};
        vecs[2] = '{core: 3, we: 1'b1, addr: 16'hFFFF, wdata: 8'hFF, exp_ack: 4'b1000, exp_rdata: 8'h00, exp_lat: 2};
        vecs[3] = '{core: 1, we: 1'b0, addr: 16'hBEEF, wdata: 8'h77, exp_ack: 4'b0010, exp_rdata: 8'h19, exp_lat: 3};
        vecs[4] = '{core: 0, we: 1'b1, addr: 16'h8001, wdata: 8'h01, exp_ack: 4'b0001, exp_rdata: 8'h00, exp_lat: 2};
        vecs[5] = '{core: 3, we: 1'b0, addr: 16'h00F0, wdata: 8'h00, exp_ack: 4'b1000, exp_rdata: 8'h1A, exp_lat: 3};

        clk = 1'b0; rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        #2 rst = 1'b0;
        #1 chk("reset_outputs", 64'({gnt, ack, rdata, mem_addr, mem_wdata, mem_we, busy}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single isolated transactions.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].core, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            begin
                exp_t e;
                e.ack = vecs[i].exp_ack; e.we = vecs[i].we; e.addr = vecs[i].addr;
                e.wdata = vecs[i].wdata; e.rdata = vecs[i].exp_rdata;
                exp_q.push_back(e);
            end
            lat = -1;
            for (int c = 0; c < 20 && lat < 0; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    chk("issue_gnt", 64'(gnt), 64'(vecs[i].exp_ack));
                    chk("issue_addr", 64'(mem_addr), 64'(vecs[i].addr));
                    chk("issue_we", 64'(mem_we), 64'(vecs[i].we));
                    chk("issue_busy", 64'(busy), 64'd1);
                    if (vecs[i].we) chk("issue_wdata", 64'(mem_wdata), 64'(vecs[i].wdata));
                end
                if (ack != '0) begin
                    lat = c;
                    chk("done_busy", 64'(busy), 64'd1);
                    req[vecs[i].core] = 1'b0;
                end
            end
            chk("latency", 64'(lat), 64'(vecs[i].exp_lat));
            @(negedge clk);
            chk("idle_after", 64'({busy, gnt, mem_we, ack}), 64'd0);
        end

        // All cores reading continuously: grant order follows the pointer.
        @(posedge clk); #1;
        for (int c = 0; c < NC; c++) drive(c, 1'b0, 16'(16'h0100 * c + 16'h0010 + c), 8'h00);
        for (int k = 0; k < 5; k++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
            push(0, 1'b0, 16'h0010, 8'h00);
`else
            push(k % NC, 1'b0, 16'(16'h0100 * (k % NC) + 16'h0010 + (k % NC)), 8'h00);
`endif
        end
        wait_acks(5, 1'b0, 60);
        req = '0;
        repeat (3) @(negedge clk);

        // Back-to-back writes from one core with req held across the ack.
        @(posedge clk); #1;
        drive(1, 1'b1, 16'h0100, 8'h11);
        push(1, 1'b1, 16'h0100, 8'h11);
        push(1, 1'b1, 16'h0001, 8'h22);
        n = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            @(negedge clk);
            if (ack[1]) begin
                n++;
                if (n == 1) begin
                    addr[AW +: AW] = 16'h0001;
                    wdata[DW +: DW] = 8'h22;
                end else begin
                    req[1] = 1'b0;
                end
            end
        end
        #1;
        chk("b2b_acks", 64'(n), 64'd2);
        if (ack_times.size() >= 2)
            chk("b2b_spacing", 64'(ack_times[ack_times.size()-1] - ack_times[ack_times.size()-2]), 64'd3);
        repeat (3) @(negedge clk);

        // Early drop: core 3 releases req during ISSUE; access still completes once.
        @(posedge clk); #1;
        base = ack_count;
        drive(3, 1'b1, 16'h0333, 8'h5C);
        push(3, 1'b1, 16'h0333, 8'h5C);
        @(negedge clk);
        @(negedge clk);
        chk("drop_issue_we", 64'(mem_we), 64'd1);
        req[3] = 1'b0;
        wait_acks(1, 1'b1, 10);
        repeat (6) @(negedge clk);
        chk("drop_single_ack", 64'(ack_count - base), 64'd1);

        // Reset during WAIT of core 1's read, after core 0 moved the pointer to 1.
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h0050, 8'h3E);
        push(0, 1'b1, 16'h0050, 8'h3E);
        wait_acks(1, 1'b1, 20);
        @(negedge clk);
        @(posedge clk); #1;
        drive(1, 1'b0, 16'h0033, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", 64'({busy, gnt}), 64'({1'b1, 4'b0010}));
        #1 rst = 1'b0;
        req = '0;
        #1 chk("rst_async_outputs", 64'({gnt, ack, rdata, mem_addr, mem_wdata, mem_we, busy}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        base = ack_count;
        repeat (4) @(negedge clk);
        chk("rst_no_ack", 64'(ack_count - base), 64'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0060, 8'h00);
        drive(1, 1'b0, 16'h0033, 8'h00);
        push(0, 1'b0, 16'h0060, 8'h00);
        push(1, 1'b0, 16'h0033, 8'h00);
        wait_acks(2, 1'b1, 30);
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares one single-port data DRAM among NUM_CORES matrix-multiplication cores in the multi-core build.
- Each core posts an address, a write enable and write data through a req/ack handshake.
- The arbiter grants one core at a time in round-robin order, drives the DRAM address, data and write-enable lines, and returns read data.
- It sits between the cores' AR/bus/dram_wrEn outputs and the DRAM, replacing each core's direct DRAM connection.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, address width (matches the core AR register).
- DATA_W, 8, DRAM data width.
- RD_LAT, 1, cycles from mem_addr valid to mem_rdata valid (1..4).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req  input  NUM_CORES  per-core access request, held until ack.
- we  input  NUM_CORES  per-core write (1) / read (0), stable while req is high.
- addr  input  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  input  NUM_CORES*DATA_W  per-core write data, same packing.
- gnt  output  NUM_CORES  one-hot, marks the core owning the current transaction.
- ack  output  NUM_CORES  one-hot, one-cycle completion pulse.
- rdata  output  DATA_W  read data, valid in the ack cycle of a read.
- mem_addr  output  ADDR_W  DRAM address.
- mem_wdata  output  DATA_W  DRAM write data.
- mem_we  output  1  DRAM write enable.
- mem_rdata  input  DATA_W  DRAM read data.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Outputs: all outputs are registered.
- Reset: asynchronous, active-low. While rst=0:
  - gnt, ack, rdata, mem_addr, mem_wdata, mem_we and busy are all 0.
  - State is IDLE and rr_ptr is 0.
- Reset mid-transaction: the transaction is abandoned immediately. mem_we drops with reset and no ack is issued.
- IDLE:
  - With no req, stay in IDLE.
  - Otherwise select the winner: the first index with req=1 searching rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
  - Latch sel, load mem_addr, mem_wdata and mem_we (= we[sel]), set gnt[sel], then go to ISSUE.
- ISSUE: lasts exactly one cycle; mem_we is high only in this cycle, and only for a write.
  - Write: go to DONE.
  - Read: load the latency counter with RD_LAT-1 and go to WAIT, or go straight to DONE if RD_LAT=1.
- WAIT: decrement the counter each cycle; go to DONE when it reaches 0. mem_addr is held throughout.
- Read-data capture: mem_rdata is captured into rdata on the cycle that enters DONE.
- DONE: lasts one cycle.
  - ack[sel] is high; rdata is valid for a read and keeps its previous value for a write.
  - On exit, gnt is cleared, rr_ptr = (sel+1) mod NUM_CORES, and the state returns to IDLE.
- Latency, counted from req sampled in IDLE at cycle t:
  - Write: mem_we is high in t+1; ack in t+2.
  - Read: mem_addr is valid from t+1; ack/rdata in t+1+RD_LAT.
- Back-to-back: there is at least one IDLE cycle between transactions. Peak rate is one write per 3 cycles.
- Requester rules:
  - Drop req on the clock edge where ack is sampled high.
  - A req still high in the IDLE cycle after ack is a new request.
  - Dropping req before ack does not cancel the access, which is committed at IDLE exit. ack still pulses.
- No arbitration in ISSUE, WAIT or DONE: new requests wait for IDLE.
- Changes to we, addr or wdata of the selected core after the IDLE exit are ignored because the values are latched.
- Fairness: with all cores requesting continuously, grants cycle 0,1,2,...,NUM_CORES-1,0. Maximum wait is NUM_CORES transactions.
- Address and data widths pass straight through with no truncation or extension.

Optional Feature:
- Macro: DRAM_ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest requesting index; rr_ptr is neither used nor updated.
- Undefined: round robin as described above.
- Timing, handshake and reset behaviour are identical in both builds.

Test Plan:
- Single write: core 2 req=1, we=1, addr=0x0040, wdata=0xA5 at cycle t -> mem_we=1, mem_addr=0x0040, mem_wdata=0xA5 in t+1 only; ack=4'b0100 in t+2; busy high in t+1..t+2.
- Single read, RD_LAT=2: memory model returns 0x3C for addr 0x0012; core 0 reads 0x0012 -> ack=4'b0001 with rdata=0x3C at t+3; mem_we stays 0.
- Round robin: all 4 cores request reads continuously from reset -> ack order 0,1,2,3,0; with the macro defined -> core 0 served every transaction.
- Reset mid-operation: assert rst=0 during WAIT of core 1's read -> all outputs 0 asynchronously; after release, no ack for core 1 until it re-requests; next grant goes to core 0 (rr_ptr=0).
- Early drop: core 3 deasserts req in ISSUE of its write -> write still performed and ack=4'b1000 pulses once; no second transaction.
- Back-to-back: core 1 keeps req high across its ack with a new address 0x0001 -> second transaction issues after one IDLE cycle, 3-cycle spacing between write acks.
